wbs_reg_bridge: RTL and testbench
=================================

Name: wbs_reg_bridge

Overview:
- Wishbone slave (responder) that accepts single WB cycles and converts each into a reg-bus transaction (cs/wr/addr/wdata/be → rdata/ack).
- Sits on the app_clk domain, behind the interconnect that arbitrates the SPI-slave WB master.
- It is the far-end responder for WB cycles issued toward the SSPI/peripheral register blocks.
- Adds address-window check, bus timeout and error response.

Parameters:
- REG_AW, 9, reg-bus byte address width; reg_addr = wbs_adr_i[REG_AW-1:0].
- BASE_HI, 23'h0, required value of wbs_adr_i[31:REG_AW]; mismatch is a decode error.
- TO_W, 8, timeout counter width; timeout fires after 2**TO_W-1 REQ cycles without reg_ack.
- ERR_DATA, 32'hDEAD_0E55, value driven on wbs_dat_o with wbs_err_o.

Ports:
- app_clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- wbs_cyc_i  in  1  WB cycle.
- wbs_stb_i  in  1  WB strobe.
- wbs_adr_i  in  32  WB byte address.
- wbs_we_i  in  1  write enable.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte select.
- wbs_dat_o  out  32  read data; valid with ack or err.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_err_o  out  1  one-cycle error (decode miss or timeout).
- reg_cs  out  1  reg-bus chip select.
- reg_wr  out  1  reg-bus write.
- reg_addr  out  REG_AW  reg-bus address.
- reg_wdata  out  32  reg-bus write data.
- reg_be  out  4  reg-bus byte enables.
- reg_rdata  in  32  reg-bus read data, sampled with reg_ack.
- reg_ack  in  1  reg-bus acknowledge.

Behaviour:
- Reset (async, reset=1): state=IDLE. All outputs 0, including wbs_dat_o and reg_addr. Timeout counter 0, abort flag 0.
- FSM states: IDLE, REQ, RESP, ERR.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i, register adr/we/dat/sel.
  - If wbs_adr_i[31:REG_AW]==BASE_HI: go to REQ with reg_cs=1 from the next cycle.
  - Otherwise: go to ERR; reg_cs is never asserted.
- REQ:
  - reg_cs held at 1; reg_wr/addr/wdata/be stable from the captured values.
  - Counter increments each cycle.
  - On reg_ack: capture reg_rdata (captured even for writes), drop reg_cs next cycle, go to RESP.
  - If the counter reaches all-ones without reg_ack: drop reg_cs, go to ERR.
  - reg_ack in the same cycle as the terminal count: ack wins → RESP.
- RESP: wbs_ack_o=1 and wbs_dat_o=captured rdata for exactly one cycle, then IDLE.
- ERR: wbs_err_o=1 and wbs_dat_o=ERR_DATA for one cycle, then IDLE.
- Outputs: wbs_ack_o and wbs_err_o are never both 1. Both are registered.
- Latency: stb sampled at cycle N → reg_cs at N+1 → reg_ack at N+1+k → wbs_ack at N+2+k. Minimum 2 cycles; decode error at N+1.
- wbs_cyc_i dropped during REQ:
  - The reg transaction runs to ack or timeout; it cannot be aborted.
  - The abort flag is set, and RESP/ERR then suppress wbs_ack_o/wbs_err_o.
  - The state still returns to IDLE.
- A new stb is accepted only in IDLE. In-flight request inputs are ignored after capture.
- reg_ack outside REQ is ignored.
- Counter clears on entry to REQ and never wraps.
- Reset asserted mid-REQ: immediate return to IDLE with reg_cs=0; no WB response is issued.

Decomposition:
- Package wbs_reg_pkg: state enum (IDLE/REQ/RESP/ERR, 2 bits) and the default ERR_DATA constant.
- No sub-module. The timeout counter is inline, since the whole block is a single FSM.

Test Plan:
- Write, adr=0x0000_0044, dat=0x1234_5678, sel=4'hF; responder acks 3 cycles after cs → reg_addr=9'h044, reg_wr=1, wdata matches; wbs_ack_o 1 cycle at N+5; err=0.
- Read, adr=0x0000_0010; reg_ack in the same cycle as cs with rdata=0xA5A5_0001 → wbs_dat_o=0xA5A5_0001, ack at N+2.
- Decode miss, adr=0x0000_0200 (BASE_HI=0) → reg_cs never high; wbs_err_o at N+1 with dat=0xDEAD_0E55.
- Timeout: responder never acks → reg_cs high for 255 cycles then low; wbs_err_o one cycle; next stb is accepted normally.
- Ack on the terminal timeout cycle → wbs_ack_o, not err.
- cyc dropped 2 cycles into REQ; reg_ack later → no wbs_ack_o/err; FSM back in IDLE; a following read completes normally. A reset pulse mid-REQ → all outputs 0 the same cycle.

Source files
------------

// File: rtl/wbs_reg_pkg.sv
// Shared types and constants for the Wishbone to reg-bus bridge.
package wbs_reg_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2,
    StErr  = 2'd3
  } wbs_reg_state_e;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_0E55;

endpackage

// File: rtl/wbs_reg_bridge.sv
// Wishbone slave that turns single WB cycles into reg-bus transactions, with
// address-window decode, request timeout and error response.
module wbs_reg_bridge
  import wbs_reg_pkg::*;
#(
  parameter int unsigned        REG_AW   = 9,
  parameter logic [31-REG_AW:0] BASE_HI  = '0,
  parameter int unsigned        TO_W     = 8,
  parameter logic [31:0]        ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic              app_clk,
  input  logic              reset,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic              wbs_we_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [3:0]        wbs_sel_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              wbs_err_o,
  output logic              reg_cs,
  output logic              reg_wr,
  output logic [REG_AW-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic [3:0]        reg_be,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_ack
);

  // Count value of the last REQ cycle; leaving REQ there stops the count at all-ones.
  localparam logic [TO_W-1:0] CNT_TERM = {{(TO_W-1){1'b1}}, 1'b0};

  wbs_reg_state_e  state_q;
  logic [TO_W-1:0] cnt_q;
  logic            abort_q;
  logic            abort_now;

  // A master that drops cyc on the very cycle the reg-bus completes is also aborted.
  assign abort_now = abort_q | ~wbs_cyc_i;

  always_ff @(posedge app_clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      wbs_dat_o <= '0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      reg_cs    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      unique case (state_q)
        StIdle: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            reg_wr    <= wbs_we_i;
            reg_addr  <= wbs_adr_i[REG_AW-1:0];
            reg_wdata <= wbs_dat_i;
            reg_be    <= wbs_sel_i;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            if (wbs_adr_i[31:REG_AW] == BASE_HI) begin
              state_q <= StReq;
              reg_cs  <= 1'b1;
            end else begin
              state_q   <= StErr;
              wbs_err_o <= 1'b1;
              wbs_dat_o <= ERR_DATA;
            end
          end
        end
        StReq: begin
          cnt_q <= cnt_q + 1'b1;
          if (!wbs_cyc_i) abort_q <= 1'b1;
          // Ack takes priority over a timeout in the same cycle.
          if (reg_ack) begin
            reg_cs    <= 1'b0;
            state_q   <= StResp;
            wbs_ack_o <= ~abort_now;
            wbs_dat_o <= abort_now ? '0 : reg_rdata;
          end else if (cnt_q == CNT_TERM) begin
            reg_cs    <= 1'b0;
            state_q   <= StErr;
            wbs_err_o <= ~abort_now;
            wbs_dat_o <= abort_now ? '0 : ERR_DATA;
          end
        end
        StResp, StErr: begin
          state_q <= StIdle;
          abort_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wbs_reg_bridge.sv
// Directed bench for wbs_reg_bridge: vector table plus abort and reset sequences.
module tb_wbs_reg_bridge;

  localparam logic [31:0] ERR_D = 32'hDEAD_0E55;

  logic        app_clk;
  logic        reset;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_we_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        reg_cs;
  logic        reg_wr;
  logic [8:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  int n_checks = 0;
  int n_fail   = 0;

  wbs_reg_bridge #(
    .REG_AW  (9),
    .BASE_HI (23'h0),
    .TO_W    (8),
    .ERR_DATA(ERR_D)
  ) dut (
    .app_clk  (app_clk),
    .reset    (reset),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_we_i (wbs_we_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o),
    .wbs_err_o(wbs_err_o),
    .reg_cs   (reg_cs),
    .reg_wr   (reg_wr),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_be   (reg_be),
    .reg_rdata(reg_rdata),
    .reg_ack  (reg_ack)
  );

  initial app_clk = 1'b0;
  always #5 app_clk = ~app_clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          k;        // reg_ack during this cs cycle (0 = first), -1 = never
    logic [31:0] rdata;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_lat;  // cycles from stb sample edge to visible response
    int          exp_cs;   // number of cycles reg_cs is high
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    @(posedge app_clk);
    #1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    @(posedge app_clk);
    #1;
    wbs_stb_i = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    int          lat;
    int          cs_cyc;
    logic        got_ack;
    logic        got_err;
    logic [31:0] got_dat;
    bit          done;
    lat = 0; cs_cyc = 0; done = 0;
    got_ack = 1'b0; got_err = 1'b0; got_dat = '0;
    start_req(v.we, v.adr, v.dat, v.sel);
    for (int c = 1; c <= 300 && !done; c++) begin
      @(negedge app_clk);
      reg_ack = 1'b0;
      if (wbs_ack_o || wbs_err_o) begin
        done    = 1;
        lat     = c;
        got_ack = wbs_ack_o;
        got_err = wbs_err_o;
        got_dat = wbs_dat_o;
      end else if (reg_cs) begin
        if (cs_cyc == 0) begin
          check({v.name, " reg_addr"}, {23'b0, reg_addr}, {23'b0, v.adr[8:0]});
          check({v.name, " reg_wr"}, {31'b0, reg_wr}, {31'b0, v.we});
          check({v.name, " reg_be"}, {28'b0, reg_be}, {28'b0, v.sel});
          if (v.we) check({v.name, " reg_wdata"}, reg_wdata, v.dat);
        end
        if (cs_cyc == v.k) begin
          reg_ack   = 1'b1;
          reg_rdata = v.rdata;
        end
        cs_cyc++;
      end
    end
    check({v.name, " latency"}, lat, v.exp_lat);
    check({v.name, " ack"}, {31'b0, got_ack}, {31'b0, v.exp_ack});
    check({v.name, " err"}, {31'b0, got_err}, {31'b0, v.exp_err});
    check({v.name, " dat"}, got_dat, v.exp_dat);
    check({v.name, " cs cycles"}, cs_cyc, v.exp_cs);
    @(negedge app_clk);
    check({v.name, " resp one cycle"}, {30'b0, wbs_ack_o, wbs_err_o}, 32'd0);
    check({v.name, " cs idle"}, {31'b0, reg_cs}, 32'd0);
    wbs_cyc_i = 1'b0;
    reg_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1);
  end

  initial begin
    int cs_cyc;
    int seen;

    vecs[0] = '{"write", 1'b1, 32'h0000_0044, 32'h1234_5678, 4'hF, 3, 32'h0,
                1'b1, 1'b0, 32'h0, 5, 4};
    vecs[1] = '{"read", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 32'hA5A5_0001,
                1'b1, 1'b0, 32'hA5A5_0001, 2, 1};
    vecs[2] = '{"decode miss", 1'b0, 32'h0000_0200, 32'h0, 4'hF, 0, 32'h1111_1111,
                1'b0, 1'b1, ERR_D, 1, 0};
    vecs[3] = '{"timeout", 1'b0, 32'h0000_0008, 32'h0, 4'hF, -1, 32'h0,
                1'b0, 1'b1, ERR_D, 256, 255};
    vecs[4] = '{"ack at terminal", 1'b0, 32'h0000_000C, 32'h0, 4'hF, 254, 32'h0BAD_F00D,
                1'b1, 1'b0, 32'h0BAD_F00D, 256, 255};
    vecs[5] = '{"partial write", 1'b1, 32'h0000_01FC, 32'hCAFE_BEEF, 4'h3, 1, 32'h7777_0000,
                1'b1, 1'b0, 32'h7777_0000, 3, 2};

    reset = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_adr_i = '0; wbs_we_i = 1'b0;
    wbs_dat_i = '0; wbs_sel_i = '0; reg_rdata = '0; reg_ack = 1'b0;
    repeat (3) @(negedge app_clk);
    check("reset reg_cs", {31'b0, reg_cs}, 32'd0);
    check("reset wbs_ack", {31'b0, wbs_ack_o}, 32'd0);
    check("reset wbs_err", {31'b0, wbs_err_o}, 32'd0);
    check("reset wbs_dat", wbs_dat_o, 32'd0);
    check("reset reg_addr", {23'b0, reg_addr}, 32'd0);
    check("reset reg_wdata", reg_wdata, 32'd0);
    check("reset reg_be/wr", {27'b0, reg_be, reg_wr}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // Master abandons the cycle two cycles into REQ; bus completes later.
    start_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    cs_cyc = 0; seen = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge app_clk);
      reg_ack = 1'b0;
      if (wbs_ack_o || wbs_err_o) seen++;
      if (reg_cs) begin
        if (cs_cyc == 1) wbs_cyc_i = 1'b0;
        if (cs_cyc == 3) begin
          reg_ack   = 1'b1;
          reg_rdata = 32'h5555_AAAA;
        end
        cs_cyc++;
      end
    end
    check("abort no response", seen, 0);
    check("abort cs cycles", cs_cyc, 4);

    // Stray reg_ack while idle must not produce a response.
    @(negedge app_clk);
    reg_ack = 1'b1;
    @(negedge app_clk);
    reg_ack = 1'b0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge app_clk);
      if (wbs_ack_o || wbs_err_o || reg_cs) seen++;
    end
    check("idle reg_ack ignored", seen, 0);
    do_txn(vecs[1]);

    // Reset pulse in the middle of a request.
    start_req(1'b1, 32'h0000_0008, 32'hFFFF_0000, 4'hC);
    @(negedge app_clk);
    check("pre-reset cs", {31'b0, reg_cs}, 32'd1);
    @(negedge app_clk);
    reset = 1'b1;
    #1;
    check("mid-reset reg_cs", {31'b0, reg_cs}, 32'd0);
    check("mid-reset ack/err", {30'b0, wbs_ack_o, wbs_err_o}, 32'd0);
    check("mid-reset dat", wbs_dat_o, 32'd0);
    check("mid-reset reg fields", {reg_wdata[31:9], reg_addr} | {27'b0, reg_be, reg_wr}, 32'd0);
    wbs_cyc_i = 1'b0;
    @(negedge app_clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge app_clk);
      if (wbs_ack_o || wbs_err_o || reg_cs) seen++;
    end
    check("post-reset quiet", seen, 0);
    do_txn(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
